if_fetch: RTL and testbench

//   Instruction-fetch front end: the producer side of the pc/inst interface the decode stage consumes.

---
 rtl/if_fetch.sv | 152 +++++++++++++++
 tb/tb_if_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch front end: sequential word-PC generator, single-outstanding ROM
// requester, prefetch FIFO and IF/ID output register with stall/flush handling.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'd3;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_fetch_pc;

  logic [31:0]   r_pc_mem   [FIFO_DEPTH];
  logic [31:0]   r_inst_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          r_id_valid;
  logic [31:0]   r_id_pc;
  logic [31:0]   r_id_inst;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic          w_space;
  logic [31:0]   w_pc_inc;

  assign w_push       = (r_state == S_WAIT) && rom_ack_i && !flush_i;
  assign w_pop        = !flush_i && !stall_i && (r_count != '0);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  // Issue decision uses post-edge occupancy, so an outstanding request always has a slot.
  assign w_space      = (w_count_next < DEPTH_C);
  assign w_pc_inc     = r_fetch_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC_A;
      r_fetch_pc <= RESET_PC_A;
    end else begin
      if (flush_i) r_fetch_pc <= flush_pc_i & ~32'd3;
      case (r_state)
        S_IDLE: begin
          if (!flush_i && w_space) begin
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_ack_i) begin
            if (flush_i) begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_fetch_pc <= w_pc_inc;
              if (w_space) begin
                r_addr <= w_pc_inc;
              end else begin
                r_req   <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else if (flush_i) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (rom_ack_i) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_fetch_pc;
      r_inst_mem[r_wptr] <= rom_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
    end else if (flush_i) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= '0;
    end else if (!stall_i) begin
      if (w_pop) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= r_pc_mem[r_rptr];
        r_id_inst  <= r_inst_mem[r_rptr];
      end else begin
        r_id_valid <= 1'b0;
        r_id_pc    <= '0;
        r_id_inst  <= '0;
      end
    end
  end

  assign rom_req_o  = r_req;
  assign rom_addr_o = r_addr;
  assign id_valid_o = r_id_valid;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed phases push expected {pc, inst} pairs,
// a negedge monitor pops and compares each newly presented decode output.
module tb_if_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  logic        rom_req2;
  logic [31:0] rom_addr2;
  logic        rom_ack2;
  logic [31:0] rom_data2;
  logic        id_valid2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;

  exp_t        exp_q[$];
  int          nvec;
  int          nfail;
  logic [3:0]  lat;
  logic [3:0]  rom_cnt;
  logic        adv;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          idx2;
  logic [31:0] exp2 [3];

  if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF9), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0), .flush_pc_i(32'h0),
    .rom_req_o(rom_req2), .rom_addr_o(rom_addr2), .rom_ack_i(rom_ack2), .rom_data_i(rom_data2),
    .id_valid_o(id_valid2), .id_pc_o(id_pc2), .id_inst_o(id_inst2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // ROM models: main one acks after `lat` extra cycles, the wrap instance acks at once.
  assign rom_ack_i  = rom_req_o && (rom_cnt == lat);
  assign rom_data_i = rom_ack_i ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;
  assign rom_ack2   = rom_req2;
  assign rom_data2  = ~rom_addr2;

  always @(posedge clk) begin
    if (!rom_req_o || rom_ack_i) rom_cnt <= '0;
    else                         rom_cnt <= rom_cnt + 4'd1;
    adv <= !stall_i && !flush_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && adv && id_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_pc", id_pc_o, 32'hXXXX_XXXX);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("id_pc", id_pc_o, e.pc);
        chk("id_inst", id_inst_o, e.inst);
      end
    end
    if (rst && !id_valid_o) chk("bubble_inst", id_inst_o, 32'h0);
    if (rst && rom_req_o && prev_req && !prev_ack) chk("addr_stable", rom_addr_o, prev_addr);
    prev_req  = rom_req_o;
    prev_ack  = rom_ack_i;
    prev_addr = rom_addr_o;
  end

  always @(negedge clk) begin
    if (rst && id_valid2 && idx2 < 3) begin
      chk("wrap_pc", id_pc2, exp2[idx2]);
      chk("wrap_inst", id_inst2, ~exp2[idx2]);
      idx2++;
    end
  end

  task automatic run_seq(input logic [31:0] start, input int n, output int cyc);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + 32'(4 * i);
      exp_q.push_back('{pc: p, inst: rom_word(p)});
    end
    stall_i = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    stall_i = 1'b1;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_req", 32'(rom_req_o), 32'h0);
    chk("rst_addr", rom_addr_o, 32'h0);
    chk("rst_valid", 32'(id_valid_o), 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);
  endtask

  initial begin
    int cyc;
    int bound;
    nvec = 0;
    nfail = 0;
    idx2 = 0;
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;
    adv = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    lat = 4'd0;
    rst = 1'b0;
    stall_i = 1'b1;
    flush_i = 1'b0;
    flush_pc_i = '0;
    #1;
    chk_reset_outs();
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(10);

    // 1-cycle ROM, stream then stall at pc 0x8
    run_seq(32'h0, 3, cyc);
    chk("fill_drain_cycles", 32'(cyc), 32'd3);
    for (int k = 0; k < 5; k++) begin
      wait_cyc(1);
      chk("stall_valid", 32'(id_valid_o), 32'h1);
      chk("stall_pc", id_pc_o, 32'h8);
      chk("stall_inst", id_inst_o, 32'h1000_0002);
    end
    chk("full_req_low", 32'(rom_req_o), 32'h0);
    run_seq(32'hC, 2, cyc);
    chk("post_stall_cycles", 32'(cyc), 32'd2);
    run_seq(32'h14, 8, cyc);
    chk("sustained_cycles", 32'(cyc), 32'd8);

    // flush coinciding with an ack, redirect to a wrapping address
    run_seq(32'h34, 1, cyc);
    flush_i = 1'b1;
    flush_pc_i = 32'hFFFF_FFF8;
    wait_cyc(1);
    flush_i = 1'b0;
    chk("flush_valid", 32'(id_valid_o), 32'h0);
    chk("flush_pc", id_pc_o, 32'h0);
    chk("flush_req", 32'(rom_req_o), 32'h0);
    run_seq(32'hFFFF_FFF8, 4, cyc);

    // slow ROM, then asynchronous reset while a request is outstanding
    lat = 4'd3;
    wait_cyc(20);
    run_seq(32'h8, 3, cyc);
    bound = 0;
    while (!rom_req_o && bound < 20) begin
      wait_cyc(1);
      bound++;
    end
    chk("req_before_reset", 32'(rom_req_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs();
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(15);
    run_seq(32'h0, 5, cyc);

    // flush during WAIT without ack -> DROP consumes the stale response
    wait_cyc(15);
    run_seq(32'h14, 1, cyc);
    flush_i = 1'b1;
    flush_pc_i = 32'h0000_0103;
    wait_cyc(1);
    flush_i = 1'b0;
    chk("drop_req", 32'(rom_req_o), 32'h1);
    chk("drop_addr", rom_addr_o, 32'h1C);
    chk("drop_valid", 32'(id_valid_o), 32'h0);
    bound = 0;
    while (!(rom_req_o && rom_addr_o != 32'h1C) && bound < 20) begin
      wait_cyc(1);
      bound++;
    end
    chk("redirect_addr", rom_addr_o, 32'h100);
    run_seq(32'h100, 3, cyc);

    chk("wrap_count", 32'(idx2), 32'd3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
